// File: rtl/out_port_uart_tx.sv
// ============================================================================
//  Module   : out_port_uart_tx
//  Purpose  : Queues bytes written to the CPU OUT port in a small FIFO and
//             sends each one as an 8N1 UART frame on a serial pin.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module out_port_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic [7:0]            sent_count_o
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_cw = $clog2(FIFO_DEPTH + 1);
    localparam int c_tw = $clog2(CLKS_PER_BIT);

    localparam logic [c_tw-1:0] c_bit_reload = c_tw'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      c_last_bit   = 3'(DATA_WIDTH - 1);
    localparam logic [c_cw-1:0] c_full_count = c_cw'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]       r_wr_ptr;
    logic [c_aw-1:0]       r_rd_ptr;
    logic [c_cw-1:0]       r_count;
    logic                  r_overflow;

    // Transmitter state
    state_t                r_state;
    logic [c_tw-1:0]       r_timer;
    logic [2:0]            r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_tx;
    logic [7:0]            r_sent_count;

    state_t                w_state_nxt;
    logic [c_tw-1:0]       w_timer_nxt;
    logic [2:0]            w_bit_idx_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  w_tx_nxt;
    logic                  w_pop;
    logic                  w_frame_done;
    logic                  w_push;
    logic                  w_full;
    logic                  w_nonempty;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_full     = (r_count == c_full_count);
    assign w_nonempty = (r_count != '0);
    assign w_head     = r_mem[r_rd_ptr];
    // A pop on the same edge frees a slot, so a load into a full FIFO still lands.
    assign w_push     = load_i && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
            if (load_i && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_tx         <= 1'b1;
            r_sent_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            if (w_frame_done) begin
                r_sent_count <= r_sent_count + 8'd1;
            end
        end
    end

    // The shift register moves right each data bit, so the next bit is always r_shift[1].
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_pop         = 1'b0;
        w_frame_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_timer_nxt = c_bit_reload;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_timer == '0) begin
                    w_bit_idx_nxt = '0;
                    w_timer_nxt   = c_bit_reload;
                    w_tx_nxt      = r_shift[0];
                    w_state_nxt   = S_DATA;
                end else begin
                    w_timer_nxt = r_timer - c_tw'(1);
                end
            end
            S_DATA: begin
                if (r_timer == '0) begin
                    w_timer_nxt = c_bit_reload;
                    if (r_bit_idx == c_last_bit) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[DATA_WIDTH-1:1]};
                        w_tx_nxt      = r_shift[1];
                    end
                end else begin
                    w_timer_nxt = r_timer - c_tw'(1);
                end
            end
            S_STOP: begin
                if (r_timer == '0) begin
                    w_frame_done = 1'b1;
                    if (w_nonempty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_timer_nxt = c_bit_reload;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = S_START;
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer - c_tw'(1);
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign tx_o         = r_tx;
    assign busy_o       = (r_state != S_IDLE) || w_nonempty;
    assign full_o       = w_full;
    assign overflow_o   = r_overflow;
    assign sent_count_o = r_sent_count;

endmodule

`default_nettype wire

// File: tb/tb_out_port_uart_tx.sv
// ============================================================================
//  Module   : tb_out_port_uart_tx
//  Purpose  : Self-checking bench for out_port_uart_tx (CLKS_PER_BIT=4,
//             FIFO_DEPTH=4) with a cycle table and a serial-line decoder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_out_port_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_i;
    logic [7:0] data_i;
    logic       tx_o;
    logic       busy_o;
    logic       full_o;
    logic       overflow_o;
    logic [7:0] sent_count_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    out_port_uart_tx #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load_i),
        .data_i      (data_i),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .full_o      (full_o),
        .overflow_o  (overflow_o),
        .sent_count_o(sent_count_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial decoder: frame cycle index counted from the start-bit edge, bits sampled mid-bit.
    logic       mon_active = 1'b0;
    int         mon_cnt = 0;
    int         mon_start = 0;
    logic [7:0] mon_byte = 8'h00;
    int         stop_err = 0;
    logic [7:0] rx_q[$];
    int         rx_t[$];

    always @(negedge clk) begin
        if (!reset) begin
            mon_active <= 1'b0;
        end else if (!mon_active) begin
            if (tx_o == 1'b0) begin
                mon_active <= 1'b1;
                mon_cnt    <= 1;
                mon_start  <= cyc;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0)
                mon_byte[(mon_cnt - 6) / 4] <= tx_o;
            if (mon_cnt == 38) begin
                mon_active <= 1'b0;
                rx_q.push_back(mon_byte);
                rx_t.push_back(mon_start);
                if (tx_o !== 1'b1) stop_err <= stop_err + 1;
            end
        end
    end

    typedef struct {
        logic       load;
        logic [7:0] data;
        logic       tx;
        logic       busy;
        logic [7:0] sent;
    } vec_t;

    vec_t vecs[43];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        load_i = 1'b0;
        data_i = 8'h00;
        repeat (3) step();
        reset = 1'b1;
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic load_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            load_i = 1'b1;
            data_i = first + 8'(i);
            step();
        end
        load_i = 1'b0;
        data_i = 8'hEE;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("rx_frame_count", rx_q.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy_o && k < budget) begin
            step();
            k++;
        end
        chk("idle_reached", busy_o, 1'b0);
    endtask

    initial begin
        // Cycle table for a single 0x01 frame; entry k is checked just after edge k.
        for (int k = 0; k < 43; k++) begin
            vecs[k].load = (k == 0);
            vecs[k].data = (k == 0) ? 8'h01 : 8'hFF;
            vecs[k].tx   = !((k >= 2 && k <= 5) || (k >= 10 && k <= 37));
            vecs[k].busy = (k >= 1 && k <= 41);
            vecs[k].sent = (k >= 42) ? 8'd1 : 8'd0;
        end

        // Reset state and idle line
        do_reset();
        chk("rst_tx", tx_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_full", full_o, 1'b0);
        chk("rst_overflow", overflow_o, 1'b0);
        chk("rst_sent", sent_count_o, 8'd0);
        begin
            int lows = 0;
            for (int i = 0; i < 50; i++) begin
                step();
                if (tx_o !== 1'b1 || busy_o !== 1'b0) lows++;
            end
            chk("idle_50_clks", lows, 0);
        end

        // Single frame, cycle by cycle
        do_reset();
        for (int k = 0; k < 43; k++) begin
            chk($sformatf("v%0d_tx", k), tx_o, vecs[k].tx);
            chk($sformatf("v%0d_busy", k), busy_o, vecs[k].busy);
            chk($sformatf("v%0d_sent", k), sent_count_o, vecs[k].sent);
            load_i = vecs[k].load;
            data_i = vecs[k].data;
            step();
        end
        load_i = 1'b0;
        chk("t2_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("t2_byte", rx_q[0], 8'h01);

        // Two frames back to back
        do_reset();
        load_i = 1'b1; data_i = 8'hA5; step();
        data_i = 8'h3C; step();
        load_i = 1'b0; data_i = 8'h00;
        wait_rx(2, 200);
        if (rx_q.size() >= 2) begin
            chk("t3_byte0", rx_q[0], 8'hA5);
            chk("t3_byte1", rx_q[1], 8'h3C);
            chk("t3_gap", rx_t[1] - rx_t[0], 40);
        end
        step(); step();
        chk("t3_sent", sent_count_o, 8'd2);
        chk("t3_busy", busy_o, 1'b0);

        // FIFO fill and overflow
        do_reset();
        for (int i = 0; i < 6; i++) begin
            load_i = 1'b1;
            data_i = 8'h10 + 8'(i);
            step();
            if (i == 4) begin
                chk("t4_full_after5", full_o, 1'b1);
                chk("t4_ovf_after5", overflow_o, 1'b0);
            end
        end
        load_i = 1'b0; data_i = 8'hEE;
        chk("t4_ovf_after6", overflow_o, 1'b1);
        chk("t4_full_after6", full_o, 1'b1);
        wait_rx(5, 400);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            chk($sformatf("t4_byte%0d", i), rx_q[i], 8'h10 + 8'(i));
        repeat (60) step();
        chk("t4_no_extra", rx_q.size(), 5);
        chk("t4_sent", sent_count_o, 8'd5);
        chk("t4_ovf_sticky", overflow_o, 1'b1);
        chk("t4_full_drained", full_o, 1'b0);

        // Reset during data bit 3 with two bytes queued
        do_reset();
        load_bytes(8'hC3, 1);
        load_bytes(8'h5A, 1);
        load_bytes(8'h99, 1);
        repeat (15) step();
        chk("t5_bit3_value", tx_o, 1'b0);
        chk("t5_busy_before", busy_o, 1'b1);
        reset = 1'b0;
        #1;
        chk("t5_tx_async", tx_o, 1'b1);
        chk("t5_busy_async", busy_o, 1'b0);
        chk("t5_sent_async", sent_count_o, 8'd0);
        step(); step();
        reset = 1'b1;
        rx_q.delete();
        rx_t.delete();
        step();
        load_bytes(8'h7E, 1);
        wait_rx(1, 100);
        if (rx_q.size() > 0) chk("t5_byte", rx_q[0], 8'h7E);
        repeat (60) step();
        chk("t5_only_one", rx_q.size(), 1);
        chk("t5_sent", sent_count_o, 8'd1);

        // 256 frames: counter wrap
        do_reset();
        for (int k = 1; k <= 255; k++) begin
            load_bytes(8'(k), 1);
            repeat (39) step();
        end
        wait_idle(200);
        chk("t6_sent_255", sent_count_o, 8'd255);
        chk("t6_rx_255", rx_q.size(), 255);
        if (rx_q.size() > 0) chk("t6_last_byte", rx_q[rx_q.size() - 1], 8'd255);
        load_bytes(8'h00, 1);
        step();
        wait_idle(200);
        chk("t6_sent_wrap", sent_count_o, 8'd0);
        chk("t6_no_overflow", overflow_o, 1'b0);
        chk("stop_bits_high", stop_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
